// File: rtl/shifter_arb_pkg.sv
// ============================================================================
// Module  : shifter_arb_pkg
// Brief   : Shared constants, FSM encoding and shift helper for the
//           shifter_arbiter codebase slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package shifter_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  // Arbiter FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  // Shared 8-bit logical barrel shifter: left=1 moves bits toward the MSB,
  // vacated positions are zero filled.
  function automatic logic [DATA_W-1:0] shift8(
    input logic [DATA_W-1:0]  din,
    input logic [SHAMT_W-1:0] sh,
    input logic               left
  );
    if (left) return din << sh;
    else      return din >> sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shifter_arbiter_rr.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker. Returns the first set request
//           at or after the pointer, wrapping from NREQ-1 back to 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import shifter_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_idx,
  output logic            any
);

  // Two priority passes: upper segment [ptr..NREQ-1] first, then the
  // wrap-around segment, which together give rotating priority.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any     = 1'b1;
        win[i]  = 1'b1;
        win_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any     = 1'b1;
        win[i]  = 1'b1;
        win_idx = IDW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/shifter_arbiter.sv
// ============================================================================
// Module  : shifter_arbiter
// Brief   : Shares one 8-bit barrel shifter among NREQ requesters using
//           round-robin arbitration; one operation in flight, result held
//           behind a valid/ready handshake.
// Options : SHIFT_ARB_ROTATE_EN adds rot_in (per-requester rotate select).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module shifter_arbiter
  import shifter_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [DATA_W*NREQ-1:0]  data_in,
  input  logic [SHAMT_W*NREQ-1:0] shamt_in,
  input  logic [NREQ-1:0]         dir_in,
`ifdef SHIFT_ARB_ROTATE_EN
  input  logic [NREQ-1:0]         rot_in,
`endif
  output logic [NREQ-1:0]         gnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDW-1:0]          out_id
);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [DATA_W-1:0]  r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic               r_dir;
  logic [NREQ-1:0]    w_win;
  logic [IDW-1:0]     w_win_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_sel_data;
  logic [SHAMT_W-1:0] w_sel_shamt;
  logic               w_sel_dir;
  logic [DATA_W-1:0]  w_result;
  logic [IDW-1:0]     w_ptr_next;
`ifdef SHIFT_ARB_ROTATE_EN
  logic               r_rot;
  logic               w_sel_rot;
  logic [SHAMT_W-1:0] w_rev_amt;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  // Operand mux driven by the one-hot winner
  always_comb begin
    w_sel_data  = '0;
    w_sel_shamt = '0;
    w_sel_dir   = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
    w_sel_rot   = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_sel_data  = data_in[i*DATA_W +: DATA_W];
        w_sel_shamt = shamt_in[i*SHAMT_W +: SHAMT_W];
        w_sel_dir   = dir_in[i];
`ifdef SHIFT_ARB_ROTATE_EN
        w_sel_rot   = rot_in[i];
`endif
      end
    end
  end

`ifdef SHIFT_ARB_ROTATE_EN
  // Rotate = shift one way OR'd with the complementary shift by (8-shamt)
  // the other way; shamt=0 makes both terms the operand itself.
  assign w_rev_amt = ~r_shamt + 1'b1;
  assign w_result  = r_rot ? (shift8(r_data, r_shamt, r_dir) |
                              shift8(r_data, w_rev_amt, ~r_dir))
                           : shift8(r_data, r_shamt, r_dir);
`else
  assign w_result  = shift8(r_data, r_shamt, r_dir);
`endif

  assign w_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = SHIFT;
      SHIFT:   w_next_state = RESP;
      RESP:    if (out_valid && out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM output: grant is a one-cycle pulse, only in IDLE, held low in reset
  always_comb begin
    gnt = '0;
    if (!rst && (r_state == IDLE)) gnt = w_win;
  end

  // Datapath: latch operands on grant, register result, pointer on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_data    <= '0;
      r_shamt   <= '0;
      r_dir     <= 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
      r_rot     <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_id    <= w_win_idx;
          r_data  <= w_sel_data;
          r_shamt <= w_sel_shamt;
          r_dir   <= w_sel_dir;
`ifdef SHIFT_ARB_ROTATE_EN
          r_rot   <= w_sel_rot;
`endif
        end
        SHIFT: begin
          out_data  <= w_result;
          out_id    <= r_id;
          out_valid <= 1'b1;
        end
        RESP: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          r_ptr     <= w_ptr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
// ============================================================================
// Module  : tb_shifter_arbiter
// Brief   : Self-checking bench for shifter_arbiter (NREQ=2): table of
//           single-op vectors plus hand sequences for rotation fairness,
//           backpressure and mid-operation reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shifter_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] data_in;
  logic [5:0]  shamt_in;
  logic [1:0]  dir_in;
`ifdef SHIFT_ARB_ROTATE_EN
  logic [1:0]  rot_in;
`endif
  logic [1:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [0:0]  out_id;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [1:0]  rq;
    logic [15:0] dat;
    logic [5:0]  sh;
    logic [1:0]  dr;
    logic [1:0]  rt;
    logic [1:0]  egnt;
    logic [7:0]  edat;
    logic [0:0]  eid;
  } vec_t;

  vec_t vecs [8];

  shifter_arbiter #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .shamt_in  (shamt_in),
    .dir_in    (dir_in),
`ifdef SHIFT_ARB_ROTATE_EN
    .rot_in    (rot_in),
`endif
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // One complete operation with ready held high: grant, SHIFT, RESP, IDLE
  task automatic do_op(input string nm, input vec_t v);
    @(negedge clk);
    req = v.rq; data_in = v.dat; shamt_in = v.sh; dir_in = v.dr; out_ready = 1'b1;
`ifdef SHIFT_ARB_ROTATE_EN
    rot_in = v.rt;
`endif
    #1 check({nm, "_gnt"}, 16'(gnt), 16'(v.egnt));
    @(negedge clk);
    req = 2'b00;
    #1 check({nm, "_gnt_shift"}, 16'(gnt), 16'h0);
    check({nm, "_valid_shift"}, 16'(out_valid), 16'h0);
    @(negedge clk);
    #1 check({nm, "_valid"}, 16'(out_valid), 16'h1);
    check({nm, "_data"}, 16'(out_data), 16'(v.edat));
    check({nm, "_id"}, 16'(out_id), 16'(v.eid));
    @(negedge clk);
    #1 check({nm, "_valid_done"}, 16'(out_valid), 16'h0);
  endtask

  initial begin
    //          rq     dat       sh     dr     rt     egnt   edat   eid
    vecs[0] = '{2'b01, 16'hA566, 6'o53, 2'b01, 2'b00, 2'b01, 8'h30, 1'b0};
    vecs[1] = '{2'b10, 16'hFF12, 6'o71, 2'b00, 2'b00, 2'b10, 8'h01, 1'b1};
    vecs[2] = '{2'b01, 16'h0081, 6'o00, 2'b00, 2'b00, 2'b01, 8'h81, 1'b0};
    vecs[3] = '{2'b10, 16'h8100, 6'o10, 2'b10, 2'b00, 2'b10, 8'h02, 1'b1};
    vecs[4] = '{2'b01, 16'h00F0, 6'o04, 2'b00, 2'b00, 2'b01, 8'h0F, 1'b0};
    vecs[5] = '{2'b10, 16'h3C00, 6'o20, 2'b00, 2'b00, 2'b10, 8'h0F, 1'b1};
    vecs[6] = '{2'b11, 16'h8001, 6'o17, 2'b01, 2'b00, 2'b01, 8'h80, 1'b0};
    vecs[7] = '{2'b11, 16'h8001, 6'o17, 2'b01, 2'b00, 2'b10, 8'h40, 1'b1};

    rst = 1'b1; req = 2'b11; data_in = 16'hFFFF; shamt_in = '0; dir_in = '0;
    out_ready = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
    rot_in = 2'b00;
`endif
    // Reset state, with requests pending to show grant is suppressed
    @(negedge clk); @(negedge clk);
    #1 check("rst_gnt", 16'(gnt), 16'h0);
    check("rst_valid", 16'(out_valid), 16'h0);
    check("rst_data", 16'(out_data), 16'h0);
    check("rst_id", 16'(out_id), 16'h0);
    req = 2'b00; rst = 1'b0; out_ready = 1'b1;

    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // Both requesters held: grants alternate 01,10,... every third cycle
    @(negedge clk);
    req = 2'b11; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1 check($sformatf("rr_cyc%0d", k), 16'(gnt),
               (k % 3 != 0) ? 16'h0 : (((k / 3) % 2 == 0) ? 16'h1 : 16'h2));
    end
    req = 2'b00;

    // Backpressure: result held 5 cycles, later requests not granted
    @(negedge clk); @(negedge clk);
    req = 2'b01; data_in = 16'h0055; shamt_in = 6'o01; dir_in = 2'b01; out_ready = 1'b0;
    #1 check("bp_gnt", 16'(gnt), 16'h1);
    @(negedge clk);
    req = 2'b10;
    #1 check("bp_gnt_shift", 16'(gnt), 16'h0);
    @(negedge clk);
    #1 check("bp_valid", 16'(out_valid), 16'h1);
    check("bp_data", 16'(out_data), 16'h00AA);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 check($sformatf("bp_hold_valid%0d", k), 16'(out_valid), 16'h1);
      check($sformatf("bp_hold_data%0d", k), 16'(out_data), 16'h00AA);
      check($sformatf("bp_hold_id%0d", k), 16'(out_id), 16'h0);
      check($sformatf("bp_hold_gnt%0d", k), 16'(gnt), 16'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1 check("bp_release_valid", 16'(out_valid), 16'h0);
    check("bp_release_gnt", 16'(gnt), 16'h2);
    req = 2'b00;
    #1 check("withdraw_gnt", 16'(gnt), 16'h0);
    @(negedge clk);
    #1 check("withdraw_valid", 16'(out_valid), 16'h0);
    check("withdraw_gnt2", 16'(gnt), 16'h0);

    // Reset in RESP with pointer at 1: result dropped, pointer back to 0
    @(negedge clk);
    req = 2'b10; data_in = 16'h7700; out_ready = 1'b0;
    #1 check("mr_gnt", 16'(gnt), 16'h2);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    #1 check("mr_valid_pre", 16'(out_valid), 16'h1);
    rst = 1'b1;
    #1 check("mr_valid", 16'(out_valid), 16'h0);
    check("mr_data", 16'(out_data), 16'h0);
    check("mr_id", 16'(out_id), 16'h0);
    check("mr_gnt0", 16'(gnt), 16'h0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check($sformatf("mr_no_result%0d", k), 16'(out_valid), 16'h0);
    end
    @(negedge clk);
    req = 2'b11;
    #1 check("mr_ptr_zero", 16'(gnt), 16'h1);
    req = 2'b00;

`ifdef SHIFT_ARB_ROTATE_EN
    do_op("rot1", '{2'b01, 16'h0081, 6'o01, 2'b01, 2'b01, 2'b01, 8'h03, 1'b0});
    do_op("rot0", '{2'b01, 16'h0081, 6'o01, 2'b01, 2'b00, 2'b01, 8'h02, 1'b0});
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
